// File: rtl/conv_pkg.sv
// Shared widths and FSM encoding for the conv/ReLU/pool post-processor.
package conv_pkg;
    localparam int DefaultDataWidth = 32;
    localparam int DefaultAddrWidth = 16;
    localparam int DimWidth = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;
endpackage

// File: rtl/conv_relu_pool_if.sv
// Control handshake plus accumulation-buffer read port and pool-buffer write port.
interface conv_relu_pool_if
    import conv_pkg::*;
#(
    parameter int DataWidth = DefaultDataWidth,
    parameter int AddrWidth = DefaultAddrWidth
);
    logic                 start;
    logic [DimWidth-1:0]  row_in;
    logic [DimWidth-1:0]  col_in;
    logic [DataWidth-1:0] bias_in;
    logic                 rd_en_acc;
    logic [AddrWidth-1:0] rd_addr_acc;
    logic [DataWidth-1:0] rd_data_acc;
    logic                 wr_en_pool;
    logic [AddrWidth-1:0] wr_addr_pool;
    logic [DataWidth-1:0] wr_data_pool;
    logic                 busy;
    logic                 done;

    modport master (
        output start, row_in, col_in, bias_in, rd_data_acc,
        input  rd_en_acc, rd_addr_acc, wr_en_pool, wr_addr_pool, wr_data_pool, busy, done
    );

    modport slave (
        input  start, row_in, col_in, bias_in, rd_data_acc,
        output rd_en_acc, rd_addr_acc, wr_en_pool, wr_addr_pool, wr_data_pool, busy, done
    );
endinterface

// File: rtl/pool_addr_gen.sv
// Walks the 2x2 pooling windows row-major, emitting 1-based accumulation-buffer
// read addresses in quad order (top-left, top-right, bottom-left, bottom-right).
module pool_addr_gen
    import conv_pkg::*;
#(
    parameter int AddrWidth = DefaultAddrWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic [DimWidth-1:0]  col,
    input  logic [DimWidth-1:0]  pool_rows,
    input  logic [DimWidth-1:0]  pool_cols,
    output logic [AddrWidth-1:0] addr,
    output logic [1:0]           quad,
    output logic                 last
);
    localparam int SelW  = DimWidth + 1;
    localparam int ProdW = 2 * SelW;

    logic [DimWidth-1:0] pi, pj, ni, nj;
    logic [1:0]          nq;
    logic [SelW-1:0]     row_sel, col_sel;
    logic [ProdW-1:0]    lin;
    logic [AddrWidth-1:0] next_addr;

    assign last = (pi == pool_rows - DimWidth'(1)) && (pj == pool_cols - DimWidth'(1))
                  && (quad == 2'd3);

    // Address of the following read; the +1 makes the buffer 1-based.
    always_comb begin
        nq = quad + 2'd1;
        ni = pi;
        nj = pj;
        if (quad == 2'd3) begin
            if (pj == pool_cols - DimWidth'(1)) begin
                nj = '0;
                ni = pi + DimWidth'(1);
            end else begin
                nj = pj + DimWidth'(1);
            end
        end
        row_sel   = {ni, nq[1]};
        col_sel   = {nj, nq[0]};
        lin       = ({{SelW{1'b0}}, row_sel} * {{(SelW + 1){1'b0}}, col})
                    + {{SelW{1'b0}}, col_sel} + ProdW'(1);
        next_addr = AddrWidth'(lin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi   <= '0;
            pj   <= '0;
            quad <= '0;
            addr <= '0;
        end else if (load) begin
            pi   <= '0;
            pj   <= '0;
            quad <= '0;
            addr <= AddrWidth'(1);
        end else if (advance) begin
            pi   <= ni;
            pj   <= nj;
            quad <= nq;
            addr <= next_addr;
        end
    end
endmodule

// File: rtl/conv_relu_pool.sv
// 2x2 max-pool of a finished accumulation map, then saturating bias add and ReLU;
// one pooled sample is written every four read cycles.
module conv_relu_pool
    import conv_pkg::*;
#(
    parameter int DataWidth = DefaultDataWidth,
    parameter int AddrWidth = DefaultAddrWidth
) (
    input logic             Clk,
    input logic             Rst_n,
    conv_relu_pool_if.slave bus
);
    state_e state, next_state;

    logic [DimWidth-1:0]  pr_in, pc_in, pr_q, pc_q, col_q;
    logic [DataWidth-1:0] bias_q, max_q, cand, result, wr_data_q;
    logic [DataWidth:0]   sum;
    logic [AddrWidth-1:0] pool_total, wr_cnt, wr_addr_q, rd_addr;
    logic [1:0]           quad, quad_d;
    logic                 has_work, accept, last_read, last_write;
    logic                 rd_vld_d, wr_en_q, done_q;

    assign pr_in      = bus.row_in >> 1;
    assign pc_in      = bus.col_in >> 1;
    assign has_work   = (pr_in != '0) && (pc_in != '0);
    assign accept     = (state == IDLE) && bus.start;
    assign last_write = wr_en_q && (wr_addr_q == pool_total);

    pool_addr_gen #(.AddrWidth(AddrWidth)) u_addr_gen (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (accept && has_work),
        .advance  ((state == RUN) && !last_read),
        .col      (col_q),
        .pool_rows(pr_q),
        .pool_cols(pc_q),
        .addr     (rd_addr),
        .quad     (quad),
        .last     (last_read)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start && has_work) next_state = RUN;
            RUN:     if (last_read) next_state = FLUSH;
            FLUSH:   if (last_write) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Max of the window so far, then the 33-bit biased sum clamped and rectified.
    always_comb begin
        cand = max_q;
        if ((quad_d == 2'd0) || ($signed(bus.rd_data_acc) > $signed(max_q)))
            cand = bus.rd_data_acc;
        sum    = {cand[DataWidth-1], cand} + {bias_q[DataWidth-1], bias_q};
        result = sum[DataWidth-1:0];
        if (sum[DataWidth])
            result = '0;
        else if (sum[DataWidth-1])
            result = {1'b0, {(DataWidth - 1){1'b1}}};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pr_q       <= '0;
            pc_q       <= '0;
            col_q      <= '0;
            bias_q     <= '0;
            pool_total <= '0;
            rd_vld_d   <= 1'b0;
            quad_d     <= '0;
            max_q      <= '0;
            wr_cnt     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            rd_vld_d <= (state == RUN);
            quad_d   <= quad;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            if (accept) begin
                pr_q       <= pr_in;
                pc_q       <= pc_in;
                col_q      <= bus.col_in;
                bias_q     <= bus.bias_in;
                pool_total <= AddrWidth'({{DimWidth{1'b0}}, pr_in} * {{DimWidth{1'b0}}, pc_in});
                wr_cnt     <= '0;
                if (!has_work) done_q <= 1'b1;
            end
            if (rd_vld_d) begin
                max_q <= cand;
                if (quad_d == 2'd3) begin
                    wr_en_q   <= 1'b1;
                    wr_cnt    <= wr_cnt + AddrWidth'(1);
                    wr_addr_q <= wr_cnt + AddrWidth'(1);
                    wr_data_q <= result;
                end
            end
            if ((state == FLUSH) && last_write) done_q <= 1'b1;
        end
    end

    assign bus.rd_en_acc    = (state == RUN);
    assign bus.rd_addr_acc  = rd_addr;
    assign bus.wr_en_pool   = wr_en_q;
    assign bus.wr_addr_pool = wr_addr_q;
    assign bus.wr_data_pool = wr_data_q;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_q;
endmodule

// File: tb/tb_conv_relu_pool.sv
// Directed bench for conv_relu_pool: a small buffer model answers reads, a negedge
// monitor logs strobes with cycle stamps, and the main sequence checks the logs.
module tb_conv_relu_pool;
    logic Clk = 1'b0;
    logic Rst_n;

    conv_relu_pool_if bus ();

    conv_relu_pool dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [0:63];
    int          edge_cnt = 0;

    int          wr_n = 0, rd_n = 0, busy_n = 0, done_n = 0;
    int          wr_cycle [0:63];
    logic [31:0] wr_addr_log [0:63];
    logic [31:0] wr_data_log [0:63];
    logic [31:0] rd_log [0:255];
    int          done_log [0:63];

    int pass_count = 0, total_count = 0;
    int t_start, wb, rb, bsb, db;

    always @(posedge Clk) begin
        edge_cnt <= edge_cnt + 1;
        if (bus.rd_en_acc) bus.rd_data_acc <= mem[bus.rd_addr_acc[5:0]];
    end

    // Cycle stamps: edge_cnt at a negedge equals the count of the preceding rising edge.
    always @(negedge Clk) begin
        if (bus.wr_en_pool && wr_n < 64) begin
            wr_cycle[wr_n]    <= edge_cnt;
            wr_addr_log[wr_n] <= 32'(bus.wr_addr_pool);
            wr_data_log[wr_n] <= bus.wr_data_pool;
            wr_n              <= wr_n + 1;
        end
        if (bus.rd_en_acc && rd_n < 256) begin
            rd_log[rd_n] <= 32'(bus.rd_addr_acc);
            rd_n         <= rd_n + 1;
        end
        if (bus.busy) busy_n <= busy_n + 1;
        if (bus.done && done_n < 64) begin
            done_log[done_n] <= edge_cnt;
            done_n           <= done_n + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // One map run; inject_at >= 0 fires a second start that many cycles into the run.
    task automatic apply_stimulus(input logic [8:0] rows, input logic [8:0] cols,
                                  input logic [31:0] bias, input int inject_at);
        @(posedge Clk);
        wb = wr_n; rb = rd_n; bsb = busy_n; db = done_n;
        @(negedge Clk);
        bus.start = 1'b1; bus.row_in = rows; bus.col_in = cols; bus.bias_in = bias;
        @(negedge Clk);
        t_start   = edge_cnt;
        bus.start = 1'b0;
        for (int k = 0; k < 200 && done_n == db; k++) begin
            @(posedge Clk);
            if (k == inject_at) begin
                @(negedge Clk);
                bus.start = 1'b1; bus.row_in = 9'd2; bus.col_in = 9'd2; bus.bias_in = 32'd100;
                @(negedge Clk);
                bus.start = 1'b0;
            end
        end
        repeat (3) @(posedge Clk);
    endtask

    task automatic check_writes(input string tag, input int n, input logic [31:0] e0,
                                input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] expv [0:3];
        expv[0] = e0; expv[1] = e1; expv[2] = e2; expv[3] = e3;
        check_output($sformatf("%s_wr_count", tag), 32'(wr_n - wb), 32'(n));
        for (int k = 0; k < n; k++) begin
            check_output($sformatf("%s_data%0d", tag, k), wr_data_log[wb + k], expv[k]);
            check_output($sformatf("%s_addr%0d", tag, k), wr_addr_log[wb + k], 32'(k + 1));
        end
        check_output($sformatf("%s_done_count", tag), 32'(done_n - db), 32'd1);
    endtask

    initial begin
        Rst_n = 1'b0;
        bus.start = 1'b0; bus.row_in = '0; bus.col_in = '0; bus.bias_in = '0;
        for (int k = 0; k < 64; k++) mem[k] = 32'(k);
        repeat (2) @(negedge Clk);
        check_output("reset_strobes", 32'({bus.busy, bus.done, bus.rd_en_acc, bus.wr_en_pool}), 32'd0);
        check_output("reset_rd_addr", 32'(bus.rd_addr_acc), 32'd0);
        check_output("reset_wr_addr", 32'(bus.wr_addr_pool), 32'd0);
        check_output("reset_wr_data", bus.wr_data_pool, 32'd0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // 4x4, bias 0
        apply_stimulus(9'd4, 9'd4, 32'd0, -1);
        check_writes("m4x4", 4, 32'd6, 32'd8, 32'd14, 32'd16);
        check_output("m4x4_first_wr", 32'(wr_cycle[wb] - t_start + 1), 32'd6);
        for (int k = 1; k < 4; k++)
            check_output($sformatf("m4x4_spacing%0d", k), 32'(wr_cycle[wb + k] - wr_cycle[wb + k - 1]), 32'd4);
        check_output("m4x4_done_at", 32'(done_log[db] - t_start + 1), 32'd19);
        check_output("m4x4_reads", 32'(rd_n - rb), 32'd16);
        check_output("m4x4_busy_cycles", 32'(busy_n - bsb), 32'd18);
        check_output("m4x4_first_rd", rd_log[rb], 32'd1);

        // 4x4, bias -10, with an ignored start mid-run
        apply_stimulus(9'd4, 9'd4, 32'hFFFF_FFF6, 5);
        check_writes("neg_bias", 4, 32'd0, 32'd0, 32'd4, 32'd6);
        check_output("neg_bias_done_at", 32'(done_log[db] - t_start + 1), 32'd19);

        // 5x5: odd last row and column are dropped
        apply_stimulus(9'd5, 9'd5, 32'd0, -1);
        check_writes("m5x5", 4, 32'd7, 32'd9, 32'd17, 32'd19);
        begin
            int exp_rd [0:15] = '{1, 2, 6, 7, 3, 4, 8, 9, 11, 12, 16, 17, 13, 14, 18, 19};
            check_output("m5x5_reads", 32'(rd_n - rb), 32'd16);
            for (int k = 0; k < 16; k++)
                check_output($sformatf("m5x5_rd%0d", k), rd_log[rb + k], 32'(exp_rd[k]));
        end

        // 2x2 positive saturation, then negative overflow rectified
        for (int k = 1; k <= 4; k++) mem[k] = 32'h7FFF_FFF0;
        apply_stimulus(9'd2, 9'd2, 32'h0000_0100, -1);
        check_writes("sat_pos", 1, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0);
        check_output("sat_pos_done_at", 32'(done_log[db] - t_start + 1), 32'd7);
        for (int k = 1; k <= 4; k++) mem[k] = 32'h8000_0000;
        apply_stimulus(9'd2, 9'd2, 32'hFFFF_FFFF, -1);
        check_writes("sat_neg", 1, 32'd0, 32'd0, 32'd0, 32'd0);

        // Degenerate map: PR = 0
        for (int k = 0; k < 64; k++) mem[k] = 32'(k);
        apply_stimulus(9'd1, 9'd6, 32'd0, -1);
        check_output("empty_reads", 32'(rd_n - rb), 32'd0);
        check_output("empty_writes", 32'(wr_n - wb), 32'd0);
        check_output("empty_busy", 32'(busy_n - bsb), 32'd0);
        check_output("empty_done_count", 32'(done_n - db), 32'd1);
        check_output("empty_done_at", 32'(done_log[db] - t_start + 1), 32'd1);

        // Reset after the second write abandons the map
        @(posedge Clk);
        wb = wr_n; rb = rd_n; db = done_n;
        @(negedge Clk);
        bus.start = 1'b1; bus.row_in = 9'd4; bus.col_in = 9'd4; bus.bias_in = 32'd0;
        @(negedge Clk);
        bus.start = 1'b0;
        for (int k = 0; k < 100 && (wr_n - wb) < 2; k++) @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check_output("rst_mid_strobes", 32'({bus.busy, bus.done, bus.rd_en_acc, bus.wr_en_pool}), 32'd0);
        check_output("rst_mid_rd_addr", 32'(bus.rd_addr_acc), 32'd0);
        check_output("rst_mid_wr_addr", 32'(bus.wr_addr_pool), 32'd0);
        check_output("rst_mid_wr_data", bus.wr_data_pool, 32'd0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (20) @(posedge Clk);
        check_output("rst_mid_writes", 32'(wr_n - wb), 32'd2);
        check_output("rst_mid_reads", 32'(rd_n - rb), 32'd10);
        check_output("rst_mid_no_done", 32'(done_n - db), 32'd0);

        apply_stimulus(9'd4, 9'd4, 32'd0, -1);
        check_writes("restart", 4, 32'd6, 32'd8, 32'd14, 32'd16);
        check_output("restart_done_at", 32'(done_log[db] - t_start + 1), 32'd19);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule

// File: doc/conv_relu_pool.md
CONV_RELU_POOL -- requirements
Module: conv_relu_pool

Interface
REQ-001 Parameter: DataWidth, 32, width of accumulated and output samples (two's complement).
REQ-002 Parameter: AddrWidth, 16, width of accumulation-buffer and pool-buffer addresses.
REQ-003 Port: Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: start  input  1  one-cycle request to post-process a finished accumulation map.
REQ-006 Port: row_in  input  9  map row count, latched on accepted start.
REQ-007 Port: col_in  input  9  map column count, latched on accepted start.
REQ-008 Port: bias_in  input  DataWidth  signed bias, latched on accepted start.
REQ-009 Port: rd_en_acc  output  1  read strobe to the accumulation buffer.
REQ-010 Port: rd_addr_acc  output  AddrWidth  accumulation-buffer read address, 1-based row-major, pixel (r,c) 0-based at r*col+c+1.
REQ-011 Port: rd_data_acc  input  DataWidth  read data, valid exactly one cycle after rd_en_acc.
REQ-012 Port: wr_en_pool  output  1  write strobe for one pooled sample.
REQ-013 Port: wr_addr_pool  output  AddrWidth  pooled-map address, 1-based row-major.
REQ-014 Port: wr_data_pool  output  DataWidth  pooled, biased, rectified sample.
REQ-015 Port: busy  output  1  high while a map is being processed.
REQ-016 Port: done  output  1  one-cycle pulse at end of a map.

Function
REQ-017 Pooled map: PR=floor(row/2), PC=floor(col/2); odd last row/column discarded.
REQ-018 States: IDLE, RUN, FLUSH; IDLE->RUN on start with PR>=1 and PC>=1; RUN->FLUSH after last read issued; FLUSH->IDLE after last write.
REQ-019 start sampled only in IDLE; start while busy ignored, latched values unchanged.
REQ-020 start accepted at edge T: busy high from cycle T+1, first rd_en_acc in cycle T+1.
REQ-021 Per output (i,j), reads in order (2i,2j),(2i,2j+1),(2i+1,2j),(2i+1,2j+1); outputs in row-major (i,j) order.
REQ-022 Reads issued back-to-back, one per cycle, no bubbles, for all 4*PR*PC reads.
REQ-023 Running max over the 4 samples, signed compare.
REQ-024 Result = ReLU(sat(max4 + bias)): 33-bit sum, saturated to signed DataWidth range, negatives forced to 0.
REQ-025 wr_en_pool high for one cycle, two cycles after the group's 4th read cycle (first write at T+6); one write every 4 cycles.
REQ-026 wr_addr_pool starts at 1, increments by 1 per write, ends at PR*PC.
REQ-027 done pulses in the cycle after the last wr_en_pool; busy low in that same cycle.
REQ-028 PR=0 or PC=0 on start: no reads, no writes, busy stays low, done pulses in cycle T+1.
REQ-029 rd_en_acc, wr_en_pool, done never high outside their defined cycles; addresses hold last value when strobes low.

Reset
REQ-030 Rst_n low: immediately to IDLE; busy, done, rd_en_acc, wr_en_pool 0; rd_addr_acc, wr_addr_pool, wr_data_pool 0; latched row/col/bias 0.
REQ-031 Reset mid-map abandons the map; no further reads/writes, no done; next start after release begins a fresh map.

Structure
REQ-032 Shared package conv_pkg holds DataWidth, AddrWidth, dimension width 9, and the IDLE/RUN/FLUSH state encoding.
REQ-033 One sub-module pool_addr_gen produces the read-address sequence (row/col/quad counters); datapath and FSM stay in conv_relu_pool.

Verification
REQ-034 4x4 map, buffer addr k holds k (1..16), bias 0 -> writes addr1..4 = 6,8,14,16; first write at T+6, spacing 4 cycles, done at T+19.
REQ-035 Same map, bias -10 -> writes 0,0,4,6.
REQ-036 5x5 map, addr k holds k -> reads skip row 4/col 4; writes 7,9,17,19 to addr1..4.
REQ-037 2x2 map all 0x7FFFFFF0, bias 0x00000100 -> single write 0x7FFFFFFF; all 0x80000000, bias -1 -> write 0.
REQ-038 row_in=1, col_in=6 -> no rd_en_acc/wr_en_pool, busy low, done at T+1; second start during a 4x4 run ignored.
REQ-039 Rst_n low after 2nd write of 4x4 map -> outputs 0 immediately, no done; restart yields full correct 4-write sequence.
